// File: rtl/cpu_pkg.sv
// cpu_pkg: word/memory sizing shared by the fetch path and memory_unit.
package cpu_pkg;
    localparam int CPU_WORD_SIZE = 16;
    localparam int CPU_MEM_SIZE = 256;
    localparam logic [CPU_WORD_SIZE-1:0] CPU_ADDR_MASK = CPU_WORD_SIZE'(CPU_MEM_SIZE - 1);
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered prefetch queue with push, pop and flush; head is read from storage.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(push_i);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(pop_i);
        count_d  = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch PC with branch redirect feeding a prefetch queue
// of {pc, instr} pairs to the decoder.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE = CPU_WORD_SIZE,
    parameter int MEM_SIZE = CPU_MEM_SIZE,
    parameter int DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en_i,
    input  logic                 branch_valid_i,
    input  logic [WORD_SIZE-1:0] branch_target_i,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [WORD_SIZE-1:0] instr_pc_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [WORD_SIZE-1:0] ADDR_MASK = WORD_SIZE'(MEM_SIZE - 1);
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count;
    logic [2*WORD_SIZE-1:0] head;
    logic push, pop;
    assign instr_valid_o = count != '0;
    assign pop  = instr_valid_o && instr_ready_i;
    // A pop frees a slot in the same cycle, so a full queue still accepts a push.
    assign push = fetch_en_i && !branch_valid_i && (count != CW'(DEPTH) || pop);
    always_comb begin
        fetch_pc_d = branch_valid_i ? (branch_target_i & ADDR_MASK)
                   : push ? ((fetch_pc_q + 1'b1) & ADDR_MASK) : fetch_pc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= RESET_PC & ADDR_MASK;
        else fetch_pc_q <= fetch_pc_d;
    end
    fetch_fifo #(.WIDTH(2 * WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_valid_i),
        .din_i   ({fetch_pc_q, mem_rdata_i}),
        .count_o (count),
        .head_o  (head)
    );
    assign mem_addr_o = fetch_pc_q;
    assign instr_pc_o = head[2*WORD_SIZE-1:WORD_SIZE];
    assign instr_o    = head[WORD_SIZE-1:0];
endmodule
